// File: rtl/mmult_seq.sv
// Sequential NxN matrix multiplier: C = A x B through one time-shared MAC,
// one product per cycle, with a start/busy/valid handshake.
module mmult_seq #(
  parameter  int N      = 3,
  parameter  int DW     = 8,
  parameter  int SIGNED = 0,
  localparam int CW     = 2*DW + $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [0:N*N*DW-1] A_mat,
  input  logic [0:N*N*DW-1] B_mat,
  output logic              busy,
  output logic              valid,
  output logic [0:N*N*CW-1] C_mat
);
  localparam int NE = N*N;
  localparam int IW = $clog2(N);
  localparam int EW = $clog2(NE);
  localparam logic [EW-1:0] NV   = EW'(N);
  localparam logic [IW-1:0] IMAX = IW'(N-1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;
  state_t state, state_nxt;

  logic [NE-1:0][DW-1:0] a_in, b_in, a_q, b_q;
  logic [NE-1:0][CW-1:0] res_q, c_q, c_nxt;
  logic [IW-1:0]         i_q, j_q, k_q;
  logic [CW-1:0]         acc_q, a_ext, b_ext, prod, sum;
  logic [EW-1:0]         a_sel, b_sel, c_sel;
  logic                  last_k, last_j, last_i, last_term;

  for (genvar e = 0; e < NE; e++) begin : g_elem
    assign a_in[e]           = A_mat[e*DW +: DW];
    assign b_in[e]           = B_mat[e*DW +: DW];
    assign C_mat[e*CW +: CW] = c_q[e];
  end

  assign a_sel = EW'(i_q) * NV + EW'(k_q);
  assign b_sel = EW'(k_q) * NV + EW'(j_q);
  assign c_sel = EW'(i_q) * NV + EW'(j_q);

  assign last_k    = (k_q == IMAX);
  assign last_j    = (j_q == IMAX);
  assign last_i    = (i_q == IMAX);
  assign last_term = last_k && last_j && last_i;

  // CW leaves headroom for N full-scale products, so CW-bit wraparound
  // arithmetic gives the exact signed or unsigned result.
  always_comb begin
    a_ext = CW'(a_q[a_sel]);
    b_ext = CW'(b_q[b_sel]);
    if (SIGNED != 0) begin
      a_ext = {{(CW-DW){a_q[a_sel][DW-1]}}, a_q[a_sel]};
      b_ext = {{(CW-DW){b_q[b_sel][DW-1]}}, b_q[b_sel]};
    end
  end

  assign prod = a_ext * b_ext;
  assign sum  = acc_q + prod;

  // Final element is not yet in res_q on the completion edge.
  always_comb begin
    c_nxt       = res_q;
    c_nxt[NE-1] = sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        busy      = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (last_term) state_nxt = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (state == LOAD) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (state == MAC) begin
      if (last_k) begin
        res_q[c_sel] <= sum;
        acc_q        <= '0;
        k_q          <= '0;
        if (last_j) begin
          j_q <= '0;
          i_q <= last_i ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        acc_q <= sum;
        k_q   <= k_q + 1'b1;
      end
      if (last_term) c_q <= c_nxt;
    end
  end

endmodule
